// File: rtl/reg_write_arbiter.sv
// Write controller for a bank of NREG registers: round-robin arbitration between two
// requesters for the shared load path, plus a bank-wide flush that zeroes one register per cycle.
module reg_write_arbiter #(
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req0,
  input  logic [AW-1:0]   addr0,
  input  logic [W-1:0]    data0,
  output logic            ack0,
  input  logic            req1,
  input  logic [AW-1:0]   addr1,
  input  logic [W-1:0]    data1,
  output logic            ack1,
  input  logic            flush,
  output logic            busy,
  output logic            flush_done,
  output logic [NREG-1:0] reg_ld,
  output logic [W-1:0]    reg_d
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        state;
  logic          last;
  logic [AW-1:0] count;
  logic          elig0, elig1, grant0, grant1;

  // A requester whose ack is showing is masked so a req still high on that cycle is not granted twice.
  assign elig0  = req0 & ~ack0;
  assign elig1  = req1 & ~ack1;
  assign grant0 = elig0 & (~elig1 | last);
  assign grant1 = elig1 & (~elig0 | ~last);

  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
    onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      last       <= 1'b1;
      count      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
      reg_ld     <= '0;
      reg_d      <= '0;
    end else begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      flush_done <= 1'b0;
      reg_d      <= '0;
      case (state)
        IDLE: begin
          if (flush) begin
            // Register 0 is written on the entry edge, so count already points at the next one.
            state  <= FLUSH;
            busy   <= 1'b1;
            reg_ld <= onehot(AW'(0));
            count  <= AW'(1);
          end else begin
            busy   <= 1'b0;
            reg_ld <= '0;
            if (grant0) begin
              ack0   <= 1'b1;
              reg_ld <= onehot(addr0);
              reg_d  <= data0;
            end else if (grant1) begin
              ack1   <= 1'b1;
              reg_ld <= onehot(addr1);
              reg_d  <= data1;
            end
            if (elig0 & elig1) last <= grant1;
          end
        end
        FLUSH: begin
          busy   <= 1'b1;
          reg_ld <= onehot(count);
          count  <= count + 1'b1;
          if (count == AW'(NREG - 1)) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the arbiter and flush sequence.
module tb_reg_write_arbiter;
  localparam int NREG = 4;
  localparam int AW   = 2;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            clr, req0, req1, flush;
  logic [AW-1:0]   addr0, addr1;
  logic [W-1:0]    data0, data1;
  logic            ack0, ack1, busy, flush_done;
  logic [NREG-1:0] reg_ld;
  logic [W-1:0]    reg_d;

  int checks = 0;
  int errors = 0;

  // Model state: pending flush writes as a queue of register indices, and who to favour on a tie.
  int              flush_q[$];
  int              tie_loser = 1;
  logic            m_ack0, m_ack1, m_busy, m_done;
  logic [NREG-1:0] m_ld;
  logic [W-1:0]    m_d;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREG(NREG), .AW(AW), .W(W)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .flush(flush), .busy(busy), .flush_done(flush_done),
    .reg_ld(reg_ld), .reg_d(reg_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the outputs produced by the coming rising edge from the inputs now applied.
  task automatic model_edge();
    logic e0, e1;
    int   win, idx;
    e0 = req0 && !m_ack0;
    e1 = req1 && !m_ack1;
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_ld = '0; m_d = '0;
    if (clr) begin
      flush_q.delete();
      tie_loser = 1;
      return;
    end
    if (flush_q.size() == 0 && flush)
      for (int i = 0; i < NREG; i++) flush_q.push_back(i);
    if (flush_q.size() != 0) begin
      idx = flush_q.pop_front();
      m_ld[idx] = 1'b1;
      m_busy = 1'b1;
      m_done = (flush_q.size() == 0);
      return;
    end
    win = -1;
    if (e0 && e1) begin
      win = (tie_loser == 1) ? 0 : 1;
      tie_loser = win;
    end else if (e0) win = 0;
    else if (e1) win = 1;
    if (win == 0) begin
      m_ack0 = 1'b1; m_ld[addr0] = 1'b1; m_d = data0;
    end else if (win == 1) begin
      m_ack1 = 1'b1; m_ld[addr1] = 1'b1; m_d = data1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("ack0", 32'(ack0), 32'(m_ack0));
    check("ack1", 32'(ack1), 32'(m_ack1));
    check("busy", 32'(busy), 32'(m_busy));
    check("flush_done", 32'(flush_done), 32'(m_done));
    check("reg_ld", 32'(reg_ld), 32'(m_ld));
    check("reg_d", 32'(reg_d), 32'(m_d));
    check("one_hot_ld", 32'($countones(reg_ld) <= 1), 32'(1));
    check("single_ack", 32'(ack0 & ack1), 32'(0));
  endtask

  initial begin
    clr = 1'b1; req0 = 1'b0; req1 = 1'b0; flush = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ld = '0; m_d = '0;
    step(); step();
    check("rst_ld", 32'(reg_ld), 32'(0));
    clr = 1'b0;

    // Single write with one-cycle latency.
    req0 = 1'b1; addr0 = 2; data0 = 8'hA5;
    step();
    check("t1_ld", 32'(reg_ld), 32'h4);
    check("t1_d", 32'(reg_d), 32'hA5);
    req0 = 1'b0;
    step();
    check("t1_idle", 32'(reg_ld), 32'h0);

    // Both requesting: grants alternate 0 then 1.
    req0 = 1'b1; addr0 = 0; data0 = 8'h11;
    req1 = 1'b1; addr1 = 3; data1 = 8'h33;
    step();
    check("t2_first", 32'(reg_ld), 32'h1);
    step();
    check("t2_second", 32'(reg_ld), 32'h8);
    req0 = 1'b0;
    step();
    req1 = 1'b0;
    step();

    // Flush with requester 1 waiting.
    req1 = 1'b1; addr1 = 1; data1 = 8'h77; flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_w0", 32'(reg_ld), 32'h1);
    step(); step(); step();
    check("t3_done", 32'(flush_done), 32'(1));
    step();
    check("t3_ack1", 32'(ack1), 32'(1));
    check("t3_busy", 32'(busy), 32'(0));
    req1 = 1'b0;
    step();

    // Flush and req0 on the same edge.
    flush = 1'b1; req0 = 1'b1; addr0 = 1; data0 = 8'h5A;
    step();
    flush = 1'b0;
    step(); step(); step(); step();
    check("t4_ld", 32'(reg_ld), 32'h2);
    check("t4_d", 32'(reg_d), 32'h5A);
    req0 = 1'b0;
    step();

    // Reset during the second flush cycle, then a tie resolves to requester 0.
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    clr = 1'b1;
    step();
    check("t5_busy", 32'(busy), 32'(0));
    clr = 1'b0;
    req0 = 1'b1; addr0 = 3; data0 = 8'hC3;
    req1 = 1'b1; addr1 = 0; data1 = 8'h3C;
    step();
    check("t5_tie", 32'(ack0), 32'(1));
    req0 = 1'b0;
    step();
    req1 = 1'b0;
    step();

    // Back-to-back requester 1 with req held through the ack.
    req1 = 1'b1; addr1 = 1; data1 = 8'h21;
    step();
    check("t6_a", 32'(reg_ld), 32'h2);
    addr1 = 2; data1 = 8'h42;
    step();
    check("t6_mask", 32'(reg_ld), 32'h0);
    step();
    check("t6_b", 32'(reg_ld), 32'h4);
    req1 = 1'b0;
    step();

    // Flush held as a level re-enters immediately.
    flush = 1'b1;
    for (int i = 0; i < 2 * NREG + 1; i++) step();
    flush = 1'b0;
    for (int i = 0; i < NREG; i++) step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      clr   = ($urandom_range(0, 249) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if (req0 && m_ack0) begin
        req0 = ($urandom_range(0, 1) == 1);
        addr0 = AW'($urandom); data0 = W'($urandom);
      end else if (req0) begin
        req0 = ($urandom_range(0, 19) != 0);
      end else if ($urandom_range(0, 2) == 0) begin
        req0 = 1'b1; addr0 = AW'($urandom); data0 = W'($urandom);
      end
      if (req1 && m_ack1) begin
        req1 = ($urandom_range(0, 1) == 1);
        addr1 = AW'($urandom); data1 = W'($urandom);
      end else if (req1) begin
        req1 = ($urandom_range(0, 19) != 0);
      end else if ($urandom_range(0, 2) == 0) begin
        req1 = 1'b1; addr1 = AW'($urandom); data1 = W'($urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
